// File: rtl/cw_pkg.sv
// Shared definitions for the cw-to-Wishbone bridge.
// Contents: default cw link width, bridge state encoding and the
// beat-count helper used to size the beat shifters.
package cw_pkg;

  localparam int unsigned CW_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WB    = 3'd3,
    ST_RESP  = 3'd4
  } cw_state_e;

  // Number of cw beats needed to carry a w-bit field (never less than 1).
  function automatic int unsigned ceil_div(input int unsigned w, input int unsigned cw);
    int unsigned n;
    n = (w + cw - 1) / cw;
    return (n == 0) ? 1 : n;
  endfunction

endpackage : cw_pkg

// File: rtl/cw_beat_shifter.sv
// Beat shifter between a CW_W-bit link and a W-bit parallel word.
// Load side: start_i puts a beat into slot 0, load_i into the next slot;
// slots are LSB first and bits above W in the last slot are discarded.
// Unload side: par_load_i takes a zero-padded word, shift_i moves the next
// beat down to beat_o, so unused bits of the last beat come out as 0.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   start_i, load_i     serial load controls, beat_i the inbound beat
//   par_load_i, par_i   parallel load for serial unload
//   shift_i             advance unload by one beat
//   par_o               assembled word, beat_o current outbound beat
//   cnt_o               beats loaded / beats shifted out
module cw_beat_shifter
  import cw_pkg::*;
#(
  parameter int unsigned  W     = 16,
  parameter int unsigned  CW_W  = CW_W_DEFAULT,
  localparam int unsigned NB    = ceil_div(W, CW_W),
  localparam int unsigned CNT_W = $clog2(NB + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             load_i,
  input  logic [CW_W-1:0]  beat_i,
  input  logic             par_load_i,
  input  logic [W-1:0]     par_i,
  input  logic             shift_i,
  output logic [W-1:0]     par_o,
  output logic [CW_W-1:0]  beat_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned BW = NB * CW_W;

  logic [BW-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next buffer/count; the four operations are mutually exclusive in use.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (start_i) begin
      buf_d = BW'(beat_i);
      cnt_d = CNT_W'(1);
    end else if (load_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (cnt_q == CNT_W'(k)) buf_d[k*CW_W +: CW_W] = beat_i;
      end
      if (cnt_q != CNT_W'(NB)) cnt_d = cnt_q + CNT_W'(1);
    end else if (par_load_i) begin
      buf_d = BW'(par_i);
      cnt_d = '0;
    end else if (shift_i) begin
      buf_d = buf_q >> CW_W;
      if (cnt_q != CNT_W'(NB)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign par_o  = buf_q[W-1:0];
  assign beat_o = buf_q[CW_W-1:0];
  assign cnt_o  = cnt_q;

endmodule : cw_beat_shifter

// File: rtl/cw_wb_bridge.sv
// Compressed-bus (cw) slave to classic Wishbone master bridge.
// Collects address (and write-data) beats from the cw link, runs a single
// Wishbone cycle, and returns read data as beats or a one-cycle ack/err.
// Optional bus-hang timeout: define CW_WB_TIMEOUT_EN.
// Ports:
//   i_clk, i_rst           clock, async active-low reset
//   cw_req/cw_dir/cw_sel   transfer start, direction, byte selects
//   cw_io_i / cw_io_o      inbound / outbound beats
//   cw_ack, cw_err         response pulses
//   wb_*                   Wishbone master interface
//   o_busy                 bridge not idle
module cw_wb_bridge
  import cw_pkg::*;
#(
  parameter int unsigned CW_W        = CW_W_DEFAULT,
  parameter int unsigned WB_ADDR_W   = 24,
  parameter int unsigned WB_DATA_W   = 16,
  parameter int unsigned WB_SEL_BITS = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   cw_req,
  input  logic                   cw_dir,
  input  logic [WB_SEL_BITS-1:0] cw_sel,
  input  logic [CW_W-1:0]        cw_io_i,
  output logic [CW_W-1:0]        cw_io_o,
  output logic                   cw_ack,
  output logic                   cw_err,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [WB_ADDR_W-1:0]   wb_adr,
  output logic [WB_DATA_W-1:0]   wb_o_dat,
  input  logic [WB_DATA_W-1:0]   wb_i_dat,
  output logic [WB_SEL_BITS-1:0] wb_sel,
  input  logic                   wb_ack,
  input  logic                   wb_err,
  output logic                   o_busy
);

  localparam int unsigned AB        = ceil_div(WB_ADDR_W, CW_W);
  localparam int unsigned DB        = ceil_div(WB_DATA_W, CW_W);
  // Address slots first, write data starts on the next beat boundary.
  localparam int unsigned AW_W      = AB * CW_W + WB_DATA_W;
  localparam int unsigned AW_CNT_W  = $clog2(AB + DB + 1);
  localparam int unsigned RD_CNT_W  = $clog2(DB + 1);

  cw_state_e              state_q, state_d;
  logic                   dir_q, dir_d;
  logic [WB_SEL_BITS-1:0] sel_q, sel_d;
  logic                   cyc_q, we_q, ack_q, err_q, busy_q;
  logic                   ack_d, err_d;

  logic                   aw_start, aw_load;
  logic [AW_W-1:0]        aw_par;
  logic [AW_CNT_W-1:0]    aw_cnt;
  logic [CW_W-1:0]        unused_aw_beat;
  logic                   unused_aw_par;

  logic                   rd_load, rd_shift;
  logic [CW_W-1:0]        rd_beat;
  logic [RD_CNT_W-1:0]    rd_cnt;
  logic [WB_DATA_W-1:0]   unused_rd_par;

`ifdef CW_WB_TIMEOUT_EN
  localparam int unsigned TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  // Inbound path: address beats, then write-data beats.
  cw_beat_shifter #(.W(AW_W), .CW_W(CW_W)) u_aw_shift (
    .clk_i      (i_clk),
    .rst_ni     (i_rst),
    .start_i    (aw_start),
    .load_i     (aw_load),
    .beat_i     (cw_io_i),
    .par_load_i (1'b0),
    .par_i      ('0),
    .shift_i    (1'b0),
    .par_o      (aw_par),
    .beat_o     (unused_aw_beat),
    .cnt_o      (aw_cnt)
  );

  // Outbound path: read data serialised onto cw_io_o.
  cw_beat_shifter #(.W(WB_DATA_W), .CW_W(CW_W)) u_rd_shift (
    .clk_i      (i_clk),
    .rst_ni     (i_rst),
    .start_i    (1'b0),
    .load_i     (1'b0),
    .beat_i     ('0),
    .par_load_i (rd_load),
    .par_i      (wb_i_dat),
    .shift_i    (rd_shift),
    .par_o      (unused_rd_par),
    .beat_o     (rd_beat),
    .cnt_o      (rd_cnt)
  );

  assign unused_aw_par = ^aw_par;

  // Next-state and response logic.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    sel_d    = sel_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    aw_start = 1'b0;
    aw_load  = 1'b0;
    rd_load  = 1'b0;
    rd_shift = 1'b0;
`ifdef CW_WB_TIMEOUT_EN
    tmo_d    = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cw_req) begin
          aw_start = 1'b1;
          dir_d    = cw_dir;
          sel_d    = cw_sel;
          if (AB > 1)      state_d = ST_ADDR;
          else if (cw_dir) state_d = ST_WDATA;
          else             state_d = ST_WB;
        end
      end
      ST_ADDR: begin
        aw_load = 1'b1;
        if (aw_cnt == AW_CNT_W'(AB - 1)) state_d = dir_q ? ST_WDATA : ST_WB;
      end
      ST_WDATA: begin
        aw_load = 1'b1;
        if (aw_cnt == AW_CNT_W'(AB + DB - 1)) state_d = ST_WB;
      end
      ST_WB: begin
        if (wb_err) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (wb_ack) begin
          if (dir_q) begin
            ack_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // First response beat is presented in the first RESP cycle.
            rd_load = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
`ifdef CW_WB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_RESP: begin
        rd_shift = 1'b1;
        if (rd_cnt == RD_CNT_W'(DB - 1)) state_d = ST_IDLE;
        else                             ack_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset drops cyc/stb immediately since they come straight from cyc_q.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
      cyc_q   <= (state_d == ST_WB);
      we_q    <= (state_d == ST_WB) && dir_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

`ifdef CW_WB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign wb_cyc   = cyc_q;
  assign wb_stb   = cyc_q;
  assign wb_we    = we_q;
  assign wb_adr   = aw_par[WB_ADDR_W-1:0];
  assign wb_o_dat = aw_par[AB*CW_W +: WB_DATA_W];
  assign wb_sel   = sel_q;
  assign cw_io_o  = rd_beat;
  assign cw_ack   = ack_q;
  assign cw_err   = err_q;
  assign o_busy   = busy_q;

endmodule : cw_wb_bridge

// File: tb/tb_cw_wb_bridge.sv
// Bench for cw_wb_bridge with an 8-bit cw link, 24-bit address, 16-bit data
// (3 address beats, 2 data beats). Table of transfers run back to back,
// plus reset-in-WB and, with CW_WB_TIMEOUT_EN, the bus-hang timeout.
module tb_cw_wb_bridge;

  logic        clk;
  logic        i_rst;
  logic        cw_req, cw_dir;
  logic [1:0]  cw_sel;
  logic [7:0]  cw_io_i, cw_io_o;
  logic        cw_ack, cw_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [23:0] wb_adr;
  logic [15:0] wb_o_dat, wb_i_dat;
  logic [1:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic        o_busy;

  int n_pass  = 0;
  int n_total = 0;

  cw_wb_bridge #(
    .CW_W(8), .WB_ADDR_W(24), .WB_DATA_W(16), .WB_SEL_BITS(2), .TIMEOUT(16)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .cw_req(cw_req), .cw_dir(cw_dir), .cw_sel(cw_sel),
    .cw_io_i(cw_io_i), .cw_io_o(cw_io_o),
    .cw_ack(cw_ack), .cw_err(cw_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_o_dat(wb_o_dat), .wb_i_dat(wb_i_dat),
    .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        dir;
    bit [1:0]  sel;
    bit [23:0] addr;
    bit [15:0] wdat;
    bit [15:0] rdat;
    int        waits;
    bit        err;
    bit        inject;
    bit [23:0] exp_adr;
    bit [15:0] exp_odat;
    bit        exp_we;
    bit [1:0]  exp_sel;
    bit [7:0]  exp_b0;
    bit [7:0]  exp_b1;
  } txn_t;

  txn_t tv [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Starts at a negedge in IDLE, ends at a negedge in IDLE with no response pending.
  task automatic do_txn(input txn_t t);
    cw_req  = 1'b1;
    cw_dir  = t.dir;
    cw_sel  = t.sel;
    cw_io_i = t.addr[7:0];
    @(negedge clk);
    cw_req = 1'b0;
    chk("busy_after_req", 32'(o_busy), 1);
    if (t.inject) begin
      cw_req = 1'b1;
      cw_dir = ~t.dir;
      cw_sel = ~t.sel;
    end
    cw_io_i = t.addr[15:8];
    @(negedge clk);
    cw_req  = 1'b0;
    cw_io_i = t.addr[23:16];
    @(negedge clk);
    if (t.dir) begin
      cw_io_i = t.wdat[7:0];
      @(negedge clk);
      cw_io_i = t.wdat[15:8];
      @(negedge clk);
    end
    cw_io_i  = 8'h00;
    wb_i_dat = t.rdat;
    for (int k = 0; k <= t.waits; k++) begin
      chk("cyc_held", 32'(wb_cyc), 1);
      chk("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
      chk("no_early_resp", 32'({cw_ack, cw_err}), 0);
      if (k == t.waits) begin
        chk("wb_adr", 32'(wb_adr), 32'(t.exp_adr));
        chk("wb_we", 32'(wb_we), 32'(t.exp_we));
        chk("wb_sel", 32'(wb_sel), 32'(t.exp_sel));
        if (t.exp_we) chk("wb_o_dat", 32'(wb_o_dat), 32'(t.exp_odat));
        if (t.err) wb_err = 1'b1;
        else       wb_ack = 1'b1;
      end
      @(negedge clk);
    end
    wb_ack = 1'b0;
    wb_err = 1'b0;
    chk("cyc_dropped", 32'(wb_cyc), 0);
    if (t.err) begin
      chk("err_pulse", 32'(cw_err), 1);
      chk("no_ack_on_err", 32'(cw_ack), 0);
      @(negedge clk);
      chk("err_single", 32'(cw_err), 0);
      chk("idle_after_err", 32'(o_busy), 0);
    end else if (t.dir) begin
      chk("wr_ack_pulse", 32'(cw_ack), 1);
      chk("wr_idle", 32'(o_busy), 0);
      @(negedge clk);
      chk("wr_ack_single", 32'(cw_ack), 0);
    end else begin
      chk("rd_ack0", 32'(cw_ack), 1);
      chk("rd_beat0", 32'(cw_io_o), 32'(t.exp_b0));
      @(negedge clk);
      chk("rd_ack1", 32'(cw_ack), 1);
      chk("rd_beat1", 32'(cw_io_o), 32'(t.exp_b1));
      if (t.inject) begin
        cw_req = 1'b1;
        cw_dir = 1'b1;
      end
      @(negedge clk);
      cw_req = 1'b0;
      cw_dir = 1'b0;
      chk("rd_ack_end", 32'(cw_ack), 0);
      chk("rd_io_zero", 32'(cw_io_o), 0);
      chk("rd_idle", 32'(o_busy), 0);
    end
  endtask

  initial begin
    txn_t t;
    i_rst    = 1'b1;
    cw_req   = 1'b0;
    cw_dir   = 1'b0;
    cw_sel   = 2'b00;
    cw_io_i  = 8'h00;
    wb_i_dat = 16'h0000;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;

    //          dir   sel    addr          wdat      rdat      w  err   inj   exp_adr       exp_odat  we    sel    b0     b1
    tv[0] = '{1'b1, 2'b11, 24'h123456, 16'hABCD, 16'h0000, 2, 1'b0, 1'b0, 24'h123456, 16'hABCD, 1'b1, 2'b11, 8'h00, 8'h00};
    tv[1] = '{1'b0, 2'b11, 24'h000010, 16'h0000, 16'hBEEF, 0, 1'b0, 1'b0, 24'h000010, 16'h0000, 1'b0, 2'b11, 8'hEF, 8'hBE};
    tv[2] = '{1'b0, 2'b10, 24'h000020, 16'h0000, 16'h0000, 0, 1'b1, 1'b0, 24'h000020, 16'h0000, 1'b0, 2'b10, 8'h00, 8'h00};
    tv[3] = '{1'b0, 2'b01, 24'h000ABC, 16'h0000, 16'h5AC3, 1, 1'b0, 1'b1, 24'h000ABC, 16'h0000, 1'b0, 2'b01, 8'hC3, 8'h5A};
    tv[4] = '{1'b1, 2'b01, 24'hFFFFFF, 16'h0001, 16'h0000, 0, 1'b0, 1'b0, 24'hFFFFFF, 16'h0001, 1'b1, 2'b01, 8'h00, 8'h00};
    tv[5] = '{1'b1, 2'b11, 24'h800001, 16'h7E81, 16'h0000, 1, 1'b1, 1'b0, 24'h800001, 16'h7E81, 1'b1, 2'b11, 8'h00, 8'h00};
    tv[6] = '{1'b0, 2'b11, 24'h800001, 16'h0000, 16'h00A5, 3, 1'b0, 1'b0, 24'h800001, 16'h0000, 1'b0, 2'b11, 8'hA5, 8'h00};

    // Reset state
    #1 i_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_stb", 32'(wb_stb), 0);
    chk("rst_we", 32'(wb_we), 0);
    chk("rst_adr", 32'(wb_adr), 0);
    chk("rst_odat", 32'(wb_o_dat), 0);
    chk("rst_sel", 32'(wb_sel), 0);
    chk("rst_resp", 32'({cw_ack, cw_err}), 0);
    chk("rst_io", 32'(cw_io_o), 0);
    chk("rst_busy", 32'(o_busy), 0);
    i_rst = 1'b1;
    @(negedge clk);

    // Table: transfers back to back, each request on the first IDLE cycle
    for (int i = 0; i < 7; i++) do_txn(tv[i]);

    // Reset asserted while the Wishbone cycle is open
    cw_req  = 1'b1;
    cw_dir  = 1'b0;
    cw_sel  = 2'b11;
    cw_io_i = 8'h42;
    @(negedge clk);
    cw_req  = 1'b0;
    cw_io_i = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_cyc", 32'(wb_cyc), 1);
    i_rst = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(wb_cyc), 0);
    chk("async_rst_stb", 32'(wb_stb), 0);
    chk("async_rst_resp", 32'({cw_ack, cw_err}), 0);
    chk("async_rst_busy", 32'(o_busy), 0);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    t = '{1'b0, 2'b11, 24'h000042, 16'h0000, 16'h1234, 0, 1'b0, 1'b0, 24'h000042, 16'h0000, 1'b0, 2'b11, 8'h34, 8'h12};
    do_txn(t);

`ifdef CW_WB_TIMEOUT_EN
    // Slave never answers: abort after TIMEOUT cycles, late ack ignored
    begin
      int n;
      cw_req  = 1'b1;
      cw_dir  = 1'b0;
      cw_sel  = 2'b11;
      cw_io_i = 8'h77;
      @(negedge clk);
      cw_req  = 1'b0;
      cw_io_i = 8'h00;
      @(negedge clk);
      @(negedge clk);
      n = 0;
      while (wb_cyc && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("tmo_cyc_cycles", 32'(n), 16);
      chk("tmo_err_pulse", 32'(cw_err), 1);
      chk("tmo_no_ack", 32'(cw_ack), 0);
      @(negedge clk);
      chk("tmo_err_single", 32'(cw_err), 0);
      @(negedge clk);
      @(negedge clk);
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk("late_ack_ignored", 32'({cw_ack, cw_err, o_busy, wb_cyc}), 0);
        @(negedge clk);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_cw_wb_bridge

// File: doc/cw_wb_bridge.md
Name: cw_wb_bridge

Overview:
Parametrised compressed-bus (cw) slave to Wishbone master bridge. It is the next-generation replacement for the fixed 16-bit decompressor.
- Deserialises multi-beat address and write-data transfers from a narrow cw link of width CW_W.
- Runs one classic Wishbone cycle per transfer.
- Serialises read data back as beats, with an optional bus-hang timeout.
- Sits between the core's cw port and the SoC Wishbone interconnect, in the same clock domain.

Parameters:
- CW_W, 16, cw link width in bits.
- WB_ADDR_W, 24, Wishbone address width.
- WB_DATA_W, 16, Wishbone data width.
- WB_SEL_BITS, 2, byte-select width (WB_DATA_W/8).
- TIMEOUT, 255, maximum cycles of a Wishbone cycle without ack/err (used only with the optional feature).

Ports:
- i_clk  in  1  bridge and Wishbone clock.
- i_rst  in  1  reset; one clock, reset asynchronous and active-low.
- cw_req  in  1  start of transfer; carries address beat 0.
- cw_dir  in  1  1=write, 0=read; sampled with cw_req.
- cw_sel  in  WB_SEL_BITS  byte selects; sampled with cw_req.
- cw_io_i  in  CW_W  inbound beat (address, then write data).
- cw_io_o  out  CW_W  outbound read-data beat.
- cw_ack  out  1  response valid (one cycle per read beat, one cycle for a write).
- cw_err  out  1  one-cycle error response.
- wb_cyc, wb_stb  out  1  Wishbone cycle/strobe, identical.
- wb_we  out  1  write enable.
- wb_adr  out  WB_ADDR_W  address.
- wb_o_dat  out  WB_DATA_W  write data.
- wb_i_dat  in  WB_DATA_W  read data.
- wb_sel  out  WB_SEL_BITS  byte selects.
- wb_ack, wb_err  in  1  Wishbone termination.
- o_busy  out  1  state != IDLE.

Behaviour:
- Beat counts: AB = ceil(WB_ADDR_W/CW_W), DB = ceil(WB_DATA_W/CW_W); both are at least 1.
- Beats are ordered LSB first. Excess bits of the last inbound beat are discarded. Unused bits of the last outbound beat are driven 0.
- Reset state: all outputs 0, state IDLE, counters 0. Assertion mid-transfer aborts immediately and drops wb_cyc/wb_stb asynchronously.
- State IDLE:
  - cw_req=1 captures beat 0, cw_dir and cw_sel.
  - Next state: ADDR if AB>1; else WDATA if write; else WB.
- State ADDR: captures one beat per cycle, no valid qualifier, until AB beats are held. Then goes to WDATA (write) or WB (read).
- State WDATA: captures DB beats on consecutive cycles, then goes to WB.
- State WB:
  - Asserts cyc/stb/we/adr/sel/o_dat from registers. These are stable for the whole cycle.
  - wb_ack=1 at an edge, read: latch wb_i_dat, drop cyc/stb the next cycle, go to RESP.
  - wb_ack=1 at an edge, write: pulse cw_ack for 1 cycle, go to IDLE.
  - wb_err=1 (priority over wb_ack): drop cyc/stb, pulse cw_err for 1 cycle, cw_ack stays 0, go to IDLE.
- State RESP: drives DB beats on cw_io_o with cw_ack=1 on DB consecutive cycles, then goes to IDLE.
- Timing: minimum read with AB=1, DB=1 and zero-wait slave:
  - req at T0, stb at T1, ack at T1, cw_ack/data at T2, next req accepted at T3.
- cw_req while not IDLE: ignored. A new transfer is accepted only from the first IDLE cycle after the last response.
- Single outstanding transfer; no pipelining of Wishbone cycles.

Optional Feature:
- Macro: CW_WB_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter runs in WB state.
  - Reaching TIMEOUT cycles without ack/err drops cyc/stb and pulses cw_err for 1 cycle, then returns to IDLE.
  - A late wb_ack after the abort is ignored.
- When undefined: no counter, and WB state waits indefinitely.

Decomposition:
- Shared package cw_pkg:
  - State encoding (IDLE, ADDR, WDATA, WB, RESP).
  - Beat-count function ceil_div(w, cw).
  - CW_W default.
- One natural sub-module, cw_beat_shifter, parametrised by width and CW_W:
  - Serial-to-parallel load with beat counter.
  - Parallel-to-serial unload with zero padding.
  - Instantiated twice: address/write path and read path.

Test Plan:
- CW_W=8, ADDR_W=24, DATA_W=16; write addr 0x123456, beats 56,34,12, data beats CD,AB, sel=2'b11, slave acks after 2 waits -> wb_adr=0x123456, wb_o_dat=0xABCD, wb_we=1 and cyc held 3 cycles, then single cw_ack pulse.
- Same config, read addr 0x000010, slave returns 0xBEEF zero-wait -> cw_ack high 2 consecutive cycles with cw_io_o=EF then BE, then o_busy=0.
- Read with wb_err on the 1st stb cycle -> one cw_err pulse, no cw_ack, cyc low the next cycle.
- cw_req pulsed in ADDR and RESP states -> ignored, transfer completes unchanged; req on the first IDLE cycle accepted.
- i_rst low during WB state -> wb_cyc/wb_stb/cw_ack/cw_err 0 immediately; after release, a fresh read of 0x42 completes normally.
- With CW_WB_TIMEOUT_EN, TIMEOUT=16, slave never acks -> cyc drops after 16 cycles, then one cw_err pulse; a late ack 3 cycles later produces no response.
